// File: rtl/uram_event_write_sm.sv
// Write-side sequencer for the URAM event buffer: cascaded BRAM address/enables, buffer index, occupancy.
// Writes take effect on the clk_i edge of an accepted word; starts are dropped, never stalled, when all buffers are full.
module uram_event_write_sm #(
    parameter int NBUF_BITS = 2,
    parameter int NUM_UADDR = 128
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clk_ce_i,
    input  logic                      event_start_i,
    input  logic                      dat_valid_i,
    output logic                      header_wr_o,
    output logic [$clog2(NUM_UADDR)+1:0] bram_addr_o,
    output logic [2:0]                bram_we_o,
    output logic [NBUF_BITS-1:0]      buf_idx_o,
    output logic                      data_available_o,
    input  logic                      complete_i,
    output logic                      full_o,
    output logic                      busy_o,
    output logic [15:0]               drop_count_o,
    output logic                      underflow_err_o
);
    localparam int UA_W  = $clog2(NUM_UADDR);
    localparam int CNT_W = NBUF_BITS + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << NBUF_BITS;
    localparam logic [UA_W-1:0]  LAST_UA  = UA_W'(NUM_UADDR - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_laddr;
    logic [UA_W-1:0]     r_uaddr;
    logic [2:0]          r_active;
    logic [NBUF_BITS-1:0] r_buf_idx;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_underflow_set;
    logic                r_data_avail;
    logic                r_full;
    logic [15:0]         r_drop_count;
    logic                r_underflow;

    logic w_wr, w_last, w_start, w_accept, w_drop;

    assign w_wr     = (r_state == S_WRITE) && clk_ce_i && dat_valid_i;
    assign w_last   = w_wr && r_active[2] && (r_uaddr == LAST_UA) && (r_laddr == 2'd3);
    assign w_start  = (r_state == S_IDLE) && clk_ce_i && event_start_i;
    // Decision uses the registered full flag, so a same-cycle complete_i cannot rescue a start.
    assign w_accept = w_start && !r_full;
    assign w_drop   = w_start && r_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_WRITE;
            S_WRITE: if (w_last)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_laddr  <= '0;
            r_uaddr  <= '0;
            r_active <= 3'b001;
        end else if (w_accept) begin
            r_laddr  <= '0;
            r_uaddr  <= '0;
            r_active <= 3'b001;
        end else if (w_wr) begin
            r_laddr <= r_laddr + 2'd1;
            if (r_laddr == 2'd3) begin
                r_active <= {r_active[1:0], r_active[2]};
                if (r_active[2]) r_uaddr <= r_uaddr + 1'b1;
            end
        end
    end

    always_comb begin
        w_count_nxt     = r_count;
        w_underflow_set = 1'b0;
        if (w_last && !complete_i) begin
            w_count_nxt = r_count + 1'b1;
        end else if (complete_i && !w_last) begin
            if (r_count != '0) w_count_nxt = r_count - 1'b1;
            else               w_underflow_set = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_buf_idx    <= '0;
            r_count      <= '0;
            r_data_avail <= 1'b0;
            r_full       <= 1'b0;
            r_drop_count <= '0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_last) r_buf_idx <= r_buf_idx + 1'b1;
            r_count      <= w_count_nxt;
            r_data_avail <= (w_count_nxt != '0);
            r_full       <= (w_count_nxt == FULL_CNT);
            if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
            if (w_underflow_set) r_underflow <= 1'b1;
        end
    end

    assign header_wr_o      = w_accept;
    assign bram_addr_o      = {r_uaddr, r_laddr};
    assign bram_we_o        = w_wr ? r_active : 3'b000;
    assign buf_idx_o        = r_buf_idx;
    assign data_available_o = r_data_avail;
    assign full_o           = r_full;
    assign busy_o           = (r_state == S_WRITE);
    assign drop_count_o     = r_drop_count;
    assign underflow_err_o  = r_underflow;
endmodule

// File: tb/tb_uram_event_write_sm.sv
// Bench for uram_event_write_sm: write scoreboard on BRAM strobes plus directed status checks.
module tb_uram_event_write_sm;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clk_ce_i = 1'b0;
    logic        event_start_i = 1'b0;
    logic        dat_valid_i = 1'b0;
    logic        complete_i = 1'b0;
    logic        header_wr_o;
    logic [8:0]  bram_addr_o;
    logic [2:0]  bram_we_o;
    logic [1:0]  buf_idx_o;
    logic        data_available_o;
    logic        full_o;
    logic        busy_o;
    logic [15:0] drop_count_o;
    logic        underflow_err_o;

    uram_event_write_sm #(.NBUF_BITS(2), .NUM_UADDR(128)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clk_ce_i(clk_ce_i),
        .event_start_i(event_start_i), .dat_valid_i(dat_valid_i),
        .header_wr_o(header_wr_o), .bram_addr_o(bram_addr_o), .bram_we_o(bram_we_o),
        .buf_idx_o(buf_idx_o), .data_available_o(data_available_o),
        .complete_i(complete_i), .full_o(full_o), .busy_o(busy_o),
        .drop_count_o(drop_count_o), .underflow_err_o(underflow_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          hdr_seen = 0;
    int          hdr_exp = 0;
    logic [1:0]  cur_buf = 2'd0;
    logic [13:0] sb[$];

    // Word k of an event: 4 low addresses per BRAM, 3 BRAMs per upper address.
    function automatic logic [8:0] exp_addr(int k);
        return 9'((((k / 12) % 128) * 4) + (k % 4));
    endfunction

    function automatic logic [13:0] exp_word(int k, logic [1:0] b);
        logic [2:0] we;
        we = 3'b001 << ((k / 4) % 3);
        return {we, exp_addr(k), b};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_evt(bit accept, bit with_complete);
        clk_ce_i      = 1'b1;
        event_start_i = 1'b1;
        complete_i    = with_complete;
        @(negedge clk_i);
        chk("hdr_strobe", 32'(header_wr_o), 32'(accept));
        @(posedge clk_i); #1;
        event_start_i = 1'b0;
        complete_i    = 1'b0;
        if (accept) hdr_exp++;
        chk("busy_after_start", 32'(busy_o), 32'(accept));
        if (accept) chk("addr_after_start", 32'(bram_addr_o), 32'd0);
    endtask

    // mode 0: back-to-back, 1: dat_valid gap after each word, 2: clk_ce gap after each word
    task automatic words(int n, int mode, bit complete_on_last);
        for (int k = 0; k < n; k++) begin
            clk_ce_i    = 1'b1;
            dat_valid_i = 1'b1;
            complete_i  = complete_on_last && (k == n - 1);
            sb.push_back(exp_word(k, cur_buf));
            @(posedge clk_i); #1;
            complete_i = 1'b0;
            if (mode != 0) begin
                if (mode == 1) dat_valid_i = 1'b0;
                else           clk_ce_i = 1'b0;
                @(negedge clk_i);
                chk("gap_we", 32'(bram_we_o), 32'd0);
                chk("gap_addr", 32'(bram_addr_o), 32'(exp_addr(k + 1)));
                @(posedge clk_i); #1;
                clk_ce_i = 1'b1;
            end
        end
        dat_valid_i = 1'b0;
    endtask

    task automatic pulse_complete();
        complete_i = 1'b1;
        @(posedge clk_i); #1;
        complete_i = 1'b0;
    endtask

    task automatic chk_status(string tag, logic avail, logic full, logic busy, logic [1:0] b);
        chk({tag, "_avail"}, 32'(data_available_o), 32'(avail));
        chk({tag, "_full"}, 32'(full_o), 32'(full));
        chk({tag, "_busy"}, 32'(busy_o), 32'(busy));
        chk({tag, "_buf"}, 32'(buf_idx_o), 32'(b));
    endtask

    initial begin
        fork
            begin : stim
                repeat (3) @(posedge clk_i);
                #1;
                chk("rst_hdr", 32'(header_wr_o), 32'd0);
                chk("rst_addr", 32'(bram_addr_o), 32'd0);
                chk("rst_we", 32'(bram_we_o), 32'd0);
                chk("rst_drop", 32'(drop_count_o), 32'd0);
                chk("rst_uflow", 32'(underflow_err_o), 32'd0);
                chk_status("rst", 1'b0, 1'b0, 1'b0, 2'd0);
                rst_i = 1'b0;
                @(posedge clk_i); #1;

                // single contiguous event
                start_evt(1'b1, 1'b0);
                words(1536, 0, 1'b0);
                cur_buf = 2'd1;
                chk_status("ev1", 1'b1, 1'b0, 1'b0, 2'd1);
                chk("ev1_addr_wrap", 32'(bram_addr_o), 32'd0);
                chk("ev1_hdr_cnt", 32'(hdr_seen), 32'(hdr_exp));

                // dat_valid gaps
                start_evt(1'b1, 1'b0);
                words(1536, 1, 1'b0);
                cur_buf = 2'd2;
                chk_status("ev2", 1'b1, 1'b0, 1'b0, 2'd2);
                chk("ev2_sb_empty", 32'(sb.size()), 32'd0);

                // clk_ce gaps; complete_i coincides with the finishing word at count 2
                start_evt(1'b1, 1'b0);
                words(1536, 2, 1'b1);
                cur_buf = 2'd3;
                chk_status("ev3", 1'b1, 1'b0, 1'b0, 2'd3);

                start_evt(1'b1, 1'b0);
                words(1536, 0, 1'b0);
                cur_buf = 2'd0;
                chk_status("ev4", 1'b1, 1'b0, 1'b0, 2'd0);
                start_evt(1'b1, 1'b0);
                words(1536, 0, 1'b0);
                cur_buf = 2'd1;
                chk_status("ev5", 1'b1, 1'b1, 1'b0, 2'd1);

                // full: drop, then drop with simultaneous complete_i
                start_evt(1'b0, 1'b0);
                chk("drop1_cnt", 32'(drop_count_o), 32'd1);
                chk_status("drop1", 1'b1, 1'b1, 1'b0, 2'd1);
                start_evt(1'b0, 1'b1);
                chk("drop2_cnt", 32'(drop_count_o), 32'd2);
                chk_status("drop2", 1'b1, 1'b0, 1'b0, 2'd1);
                chk("drop_hdr_cnt", 32'(hdr_seen), 32'(hdr_exp));

                // drain the remaining three events
                pulse_complete();
                pulse_complete();
                chk("drain2_avail", 32'(data_available_o), 32'd1);
                pulse_complete();
                chk("drain3_avail", 32'(data_available_o), 32'd0);
                chk("drain3_uflow", 32'(underflow_err_o), 32'd0);

                // underflow
                pulse_complete();
                chk("uflow_set", 32'(underflow_err_o), 32'd1);
                chk("uflow_avail", 32'(data_available_o), 32'd0);
                repeat (2) @(posedge clk_i);
                #1;
                chk("uflow_sticky", 32'(underflow_err_o), 32'd1);

                // reset in the middle of an event
                start_evt(1'b1, 1'b0);
                words(700, 0, 1'b0);
                rst_i = 1'b1;
                @(negedge clk_i);
                chk("mid_rst_hdr", 32'(header_wr_o), 32'd0);
                @(posedge clk_i); #1;
                chk("mid_rst_addr", 32'(bram_addr_o), 32'd0);
                chk("mid_rst_drop", 32'(drop_count_o), 32'd0);
                chk("mid_rst_uflow", 32'(underflow_err_o), 32'd0);
                chk_status("mid_rst", 1'b0, 1'b0, 1'b0, 2'd0);
                rst_i = 1'b0;
                cur_buf = 2'd0;
                @(posedge clk_i); #1;
                start_evt(1'b1, 1'b0);
                words(16, 0, 1'b0);
                chk("post_rst_addr", 32'(bram_addr_o), 32'd4);
                chk("post_rst_busy", 32'(busy_o), 32'd1);
                @(negedge clk_i);
                chk("end_sb_empty", 32'(sb.size()), 32'd0);
                chk("end_hdr_cnt", 32'(hdr_seen), 32'(hdr_exp));
            end
            begin : monitor
                logic [13:0] e;
                forever begin
                    @(negedge clk_i);
                    if (header_wr_o) hdr_seen++;
                    if (bram_we_o != 3'b000) begin
                        n_cmp++;
                        if (sb.size() == 0) begin
                            n_bad++;
                            $display("FAIL unexpected_write: we=%b addr=%h buf=%0d, none expected",
                                     bram_we_o, bram_addr_o, buf_idx_o);
                        end else begin
                            e = sb.pop_front();
                            if ({bram_we_o, bram_addr_o, buf_idx_o} !== e) begin
                                n_bad++;
                                $display("FAIL write: got we=%b addr=%h buf=%0d expected we=%b addr=%h buf=%0d",
                                         bram_we_o, bram_addr_o, buf_idx_o, e[13:11], e[10:2], e[1:0]);
                            end
                        end
                    end
                end
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
